// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: opcode values, ALUControl
// one-hot bit positions, sequencer state encoding and opcode-class helpers.
package cpu_ctrl_pkg;

    localparam int unsigned OPW      = 5;
    localparam int unsigned ALU_NOPS = 12;

    // Opcodes (ir[31:27]); 12..31 are undefined.
    localparam logic [OPW-1:0] OP_ADD = 5'd0;
    localparam logic [OPW-1:0] OP_SUB = 5'd1;
    localparam logic [OPW-1:0] OP_AND = 5'd2;
    localparam logic [OPW-1:0] OP_OR  = 5'd3;
    localparam logic [OPW-1:0] OP_SHR = 5'd4;
    localparam logic [OPW-1:0] OP_SHL = 5'd5;
    localparam logic [OPW-1:0] OP_ROR = 5'd6;
    localparam logic [OPW-1:0] OP_ROL = 5'd7;
    localparam logic [OPW-1:0] OP_MUL = 5'd8;
    localparam logic [OPW-1:0] OP_DIV = 5'd9;
    localparam logic [OPW-1:0] OP_NEG = 5'd10;
    localparam logic [OPW-1:0] OP_NOT = 5'd11;

    // ALUControl bit positions, same order as the opcodes.
    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_AND = 2;
    localparam int unsigned ALU_OR  = 3;
    localparam int unsigned ALU_SHR = 4;
    localparam int unsigned ALU_SHL = 5;
    localparam int unsigned ALU_ROR = 6;
    localparam int unsigned ALU_ROL = 7;
    localparam int unsigned ALU_MUL = 8;
    localparam int unsigned ALU_DIV = 9;
    localparam int unsigned ALU_NEG = 10;
    localparam int unsigned ALU_NOT = 11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_DONE
    } ctrl_state_t;

    function automatic logic op_defined(input logic [OPW-1:0] op);
        return (op <= OP_NOT);
    endfunction

    function automatic logic op_unary(input logic [OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic op_muldiv(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // One-hot ALU select for a defined opcode, all-zero otherwise.
    function automatic logic [ALU_NOPS-1:0] alu_onehot(input logic [OPW-1:0] op);
        logic [ALU_NOPS-1:0] sel;
        sel = '0;
        if (op_defined(op)) begin
            sel = {{(ALU_NOPS-1){1'b0}}, 1'b1} << op;
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Register field decoder: turns an IR register field into a one-hot
// strobe vector, all-zero when not enabled.
//   field  : register number from the IR
//   en     : drive the strobe this cycle
//   onehot : NREG-wide one-hot (or zero) strobe vector
module reg_field_decoder #(
    parameter int unsigned NREG = 16,
    parameter int unsigned FW   = 4
) (
    input  logic [FW-1:0]   field,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = {{(NREG-1){1'b0}}, 1'b1} << field;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Control sequencer for the datapath bus: runs fetch (T0-T2) and one
// register-register ALU instruction per start/done handshake.
//   clk, clr       : clock, asynchronous active-high reset
//   start          : begin an instruction (sampled only in IDLE)
//   mem_rdy        : memory read data valid
//   ir             : IR contents from the datapath
//   done/illegal/mem_err : one-cycle status pulses; busy : not IDLE
//   Rout/Rin       : one-hot register drive strobes / load enables
//   *out           : bus source strobes (at most one high per cycle)
//   *in, IncPC, MDRRead : load/control enables
//   ALUControl     : one-hot ALU operation
module ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NREG    = 16,
    parameter int unsigned ALUW    = 12,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start,
    input  logic            mem_rdy,
    input  logic [31:0]     ir,
    output logic            done,
    output logic            illegal,
    output logic            mem_err,
    output logic            busy,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            PCout,
    output logic            MDRout,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            HIout,
    output logic            LOout,
    output logic            InPortout,
    output logic            Cout,
    output logic            PCin,
    output logic            IRin,
    output logic            MARin,
    output logic            MDRin,
    output logic            Yin,
    output logic            Zin,
    output logic            HIin,
    output logic            LOin,
    output logic            IncPC,
    output logic            MDRRead,
    output logic [ALUW-1:0] ALUControl
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    ctrl_state_t state, state_nxt;
    logic [CW-1:0]  wait_cnt;
    logic           timed_out;

    logic [OPW-1:0] op_q;
    logic [3:0]     ra_q, rb_q, rc_q;

    logic           ra_en, rb_en, rc_en;
    logic [NREG-1:0] rb_oh, rc_oh;

    logic           unused_ir;
    assign unused_ir = ^ir[14:0];

    assign timed_out = (wait_cnt == CW'(TIMEOUT));

    // State register, T1 wait counter and IR field latch.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_T1 && !mem_rdy && !timed_out) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end
            // Fields are captured on the edge into T3, so ir must be
            // presented by the end of T2.
            if (state == ST_T2) begin
                op_q <= ir[31:27];
                ra_q <= ir[26:23];
                rb_q <= ir[22:19];
                rc_q <= ir[18:15];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1: begin
                if (timed_out)    state_nxt = ST_IDLE;
                else if (mem_rdy) state_nxt = ST_T2;
            end
            ST_T2:   state_nxt = ST_T3;
            ST_T3:   state_nxt = op_defined(op_q) ? ST_T4 : ST_IDLE;
            ST_T4:   state_nxt = op_unary(op_q) ? ST_DONE : ST_T5;
            ST_T5:   state_nxt = op_muldiv(op_q) ? ST_T6 : ST_DONE;
            ST_T6:   state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        done       = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        busy       = (state != ST_IDLE);
        PCout      = 1'b0;
        MDRout     = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        HIout      = 1'b0;
        LOout      = 1'b0;
        InPortout  = 1'b0;
        Cout       = 1'b0;
        PCin       = 1'b0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        IncPC      = 1'b0;
        MDRRead    = 1'b0;
        ALUControl = '0;
        ra_en      = 1'b0;
        rb_en      = 1'b0;
        rc_en      = 1'b0;
        case (state)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                MDRRead = 1'b1;
                MDRin   = 1'b1;
                mem_err = timed_out;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (!op_defined(op_q)) begin
                    illegal = 1'b1;
                end else if (op_unary(op_q)) begin
                    rb_en      = 1'b1;
                    ALUControl = ALUW'(alu_onehot(op_q));
                    Zin        = 1'b1;
                end else begin
                    rb_en = 1'b1;
                    Yin   = 1'b1;
                end
            end
            ST_T4: begin
                if (op_unary(op_q)) begin
                    Zlowout = 1'b1;
                    ra_en   = 1'b1;
                end else begin
                    rc_en      = 1'b1;
                    ALUControl = ALUW'(alu_onehot(op_q));
                    Zin        = 1'b1;
                end
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (op_muldiv(op_q)) LOin  = 1'b1;
                else                 ra_en = 1'b1;
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
        // rb and rc are never enabled in the same state, so OR-ing keeps one-hot.
        Rout = rb_oh | rc_oh;
    end

    reg_field_decoder #(.NREG(NREG), .FW(4)) u_rb_dec (
        .field  (rb_q),
        .en     (rb_en),
        .onehot (rb_oh)
    );

    reg_field_decoder #(.NREG(NREG), .FW(4)) u_rc_dec (
        .field  (rc_q),
        .en     (rc_en),
        .onehot (rc_oh)
    );

    reg_field_decoder #(.NREG(NREG), .FW(4)) u_ra_dec (
        .field  (ra_q),
        .en     (ra_en),
        .onehot (Rin)
    );

endmodule
